auto_range_fm: RTL and testbench

- Parametrised auto-ranging frequency meter. It is the behavioural successor of the fixed 3-digit, 2-range gate-level meter.
- It counts rising edges of an asynchronous F_IN during a gate window derived from CLK.
- The gate window is selectable among NRANGE decade-spaced lengths. The range is chosen automatically from the previous result, or forced manually.
- Publishes a latched BCD result with overflow flag, range index and a one-cycle DONE strobe. Sits between the pin synchroniser domain and the display/readout logic.

---
 rtl/auto_range_fm_if.sv | 26 ++
 rtl/auto_range_fm.sv | 179 +++++++++++++++++
 tb/tb_auto_range_fm.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/auto_range_fm_if.sv
// Readout bus of the auto-ranging frequency meter: measured input, range controls and latched result.
// The meter drives the result side through the slave modport.
interface auto_range_fm_if #(
   parameter int DIGITS = 3,
   parameter int NRANGE = 3
);
   localparam int RW = (NRANGE > 1) ? $clog2(NRANGE) : 1;

   logic                  F_IN;
   logic                  AUTO;
   logic [RW-1:0]         RANGE_SET;
   logic [4*DIGITS-1:0]   Q;
   logic                  Q_OVF;
   logic [RW-1:0]         RANGE;
   logic                  DONE;

   modport master (
      output F_IN, AUTO, RANGE_SET,
      input  Q, Q_OVF, RANGE, DONE
   );

   modport slave (
      input  F_IN, AUTO, RANGE_SET,
      output Q, Q_OVF, RANGE, DONE
   );
endinterface

// File: rtl/auto_range_fm.sv
// Auto-ranging BCD frequency meter: counts synchronised rising edges of F_IN over a
// decade-spaced gate window and publishes a latched result with overflow, range and DONE.
module auto_range_fm #(
   parameter int DIGITS      = 3,
   parameter int NRANGE      = 3,
   parameter int BASE_CYCLES = 10,
   parameter int RANGE_RESET = 0
) (
   input  logic           CLK,
   input  logic           nCLR,
   auto_range_fm_if.slave bus
);
   localparam int RW = (NRANGE > 1) ? $clog2(NRANGE) : 1;
   localparam int QW = 4 * DIGITS;

   function automatic logic [63:0] gate_len(input int unsigned r);
      logic [63:0] g;
      g = 64'(BASE_CYCLES);
      for (int unsigned i = 0; i < r; i++) g = g * 64'd10;
      return g;
   endfunction

   localparam logic [63:0]   MAXG   = gate_len(NRANGE - 1);
   localparam int            TW     = (MAXG > 64'd1) ? $clog2(MAXG) : 1;
   localparam logic [RW-1:0] RMAX   = RW'(NRANGE - 1);
   localparam logic [RW-1:0] RRESET = RW'(RANGE_RESET);
   localparam logic [QW-1:0] ALL9   = {DIGITS{4'd9}};

   typedef enum logic [1:0] {
      S_CLEAR,
      S_GATE,
      S_LATCH
   } state_t;

   function automatic logic [TW-1:0] gate_m1(input logic [RW-1:0] r);
      logic [TW-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < NRANGE; i++)
         if (r == RW'(i)) res = TW'(gate_len(i) - 64'd1);
      return res;
   endfunction

   function automatic logic [RW-1:0] clamp_range(input logic [RW-1:0] r);
      return (r > RMAX) ? RMAX : r;
   endfunction

   // Caller guarantees the value is not all nines.
   function automatic logic [QW-1:0] bcd_inc(input logic [QW-1:0] v);
      logic [QW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   state_t         state_q, state_d;
   logic           f_s1_q, f_s2_q, f_s3_q;
   logic           f_rise;
   logic [QW-1:0]  cnt_q, cnt_d;
   logic           ovf_q, ovf_d;
   logic [RW-1:0]  act_q, act_d;
   logic [RW-1:0]  next_q, next_d;
   logic           auto_q, auto_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [QW-1:0]  q_q, q_d;
   logic           qovf_q, qovf_d;
   logic [RW-1:0]  rng_q, rng_d;
   logic           done_q, done_d;

   assign f_rise = f_s2_q & ~f_s3_q;

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         f_s1_q  <= 1'b0;
         f_s2_q  <= 1'b0;
         f_s3_q  <= 1'b0;
      end else begin
         f_s1_q  <= bus.F_IN;
         f_s2_q  <= f_s1_q;
         f_s3_q  <= f_s2_q;
      end
   end

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         act_q   <= RRESET;
         next_q  <= RRESET;
         auto_q  <= 1'b0;
         tmr_q   <= '0;
         q_q     <= '0;
         qovf_q  <= 1'b0;
         rng_q   <= RRESET;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         act_q   <= act_d;
         next_q  <= next_d;
         auto_q  <= auto_d;
         tmr_q   <= tmr_d;
         q_q     <= q_d;
         qovf_q  <= qovf_d;
         rng_q   <= rng_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      act_d   = act_q;
      next_d  = next_q;
      auto_d  = auto_q;
      tmr_d   = tmr_q;
      q_d     = q_q;
      qovf_d  = qovf_q;
      rng_d   = rng_q;
      done_d  = 1'b0;

      case (state_q)
         S_CLEAR: begin
            cnt_d   = '0;
            ovf_d   = 1'b0;
            auto_d  = bus.AUTO;
            act_d   = bus.AUTO ? next_q : clamp_range(bus.RANGE_SET);
            tmr_d   = gate_m1(act_d);
            state_d = S_GATE;
         end

         S_GATE: begin
            if (f_rise) begin
               if (cnt_q == ALL9) ovf_d = 1'b1;
               else               cnt_d = bcd_inc(cnt_q);
            end
            if (tmr_q == '0) state_d = S_LATCH;
            else             tmr_d   = tmr_q - TW'(1);
         end

         S_LATCH: begin
            q_d    = cnt_q;
            qovf_d = ovf_q;
            rng_d  = act_q;
            done_d = 1'b1;
            // A manual measurement seeds the auto sequence with its own range.
            if (!auto_q)
               next_d = act_q;
            else if (ovf_q && (act_q != '0))
               next_d = act_q - RW'(1);
            else if ((cnt_q[QW-1 -: 4] == 4'd0) && (act_q < RMAX))
               next_d = act_q + RW'(1);
            else
               next_d = act_q;
            state_d = S_CLEAR;
         end

         default: state_d = S_CLEAR;
      endcase
   end

   assign bus.Q     = q_q;
   assign bus.Q_OVF = qovf_q;
   assign bus.RANGE = rng_q;
   assign bus.DONE  = done_q;
endmodule

// File: tb/tb_auto_range_fm.sv
// Bench for auto_range_fm: four parameterisations driven from one vector table with a
// result scoreboard, plus hand sequences for DONE timing, mid-gate changes and reset.
module tb_auto_range_fm;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   auto_range_fm_if #(.DIGITS(3), .NRANGE(3)) if0 ();
   auto_range_fm_if #(.DIGITS(2), .NRANGE(3)) if1 ();
   auto_range_fm_if #(.DIGITS(1), .NRANGE(1)) if2 ();
   auto_range_fm_if #(.DIGITS(1), .NRANGE(1)) if3 ();

   auto_range_fm #(.DIGITS(3), .NRANGE(3), .BASE_CYCLES(10),  .RANGE_RESET(0)) dut0 (.CLK(clk), .nCLR(rst_n), .bus(if0));
   auto_range_fm #(.DIGITS(2), .NRANGE(3), .BASE_CYCLES(10),  .RANGE_RESET(0)) dut1 (.CLK(clk), .nCLR(rst_n), .bus(if1));
   auto_range_fm #(.DIGITS(1), .NRANGE(1), .BASE_CYCLES(10),  .RANGE_RESET(0)) dut2 (.CLK(clk), .nCLR(rst_n), .bus(if2));
   auto_range_fm #(.DIGITS(1), .NRANGE(1), .BASE_CYCLES(100), .RANGE_RESET(0)) dut3 (.CLK(clk), .nCLR(rst_n), .bus(if3));

   int   checks   = 0;
   int   failures = 0;
   int   per [4]  = '{4, 2, 2, 2};
   int   ph  [4];
   logic f_in [4];

   assign if0.F_IN = f_in[0];
   assign if1.F_IN = f_in[1];
   assign if2.F_IN = f_in[2];
   assign if3.F_IN = f_in[3];

   // Square-wave generators; period 0 holds the input low.
   initial begin
      for (int k = 0; k < 4; k++) begin
         f_in[k] = 1'b0;
         ph[k]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (per[k] == 0) begin
               f_in[k] = 1'b0;
               ph[k]   = 0;
            end else begin
               ph[k]   = (ph[k] + 1) % per[k];
               f_in[k] = (ph[k] < per[k] / 2);
            end
         end
      end
   end

   typedef struct {
      int    dut;
      int    period;
      int    auto_;
      int    rset;
      int    exp_range;
      int    q_min;
      int    q_max;
      int    exp_ovf;
      string name;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   task automatic add_vec(input int d, input int p, input int a, input int rs,
                          input int er, input int qlo, input int qhi, input int eo, input string nm);
      vec_t v;
      v.dut = d; v.period = p; v.auto_ = a; v.rset = rs;
      v.exp_range = er; v.q_min = qlo; v.q_max = qhi; v.exp_ovf = eo; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   function automatic int bcd2int(input int v);
      int r;
      r = 0;
      for (int k = 5; k >= 0; k--) r = r * 10 + ((v >> (4 * k)) & 15);
      return r;
   endfunction

   task automatic set_in(input int d, input int a, input int rs);
      case (d)
         0: begin if0.AUTO = 1'(a); if0.RANGE_SET = 2'(rs); end
         1: begin if1.AUTO = 1'(a); if1.RANGE_SET = 2'(rs); end
         2: begin if2.AUTO = 1'(a); if2.RANGE_SET = 1'(rs); end
         default: begin if3.AUTO = 1'(a); if3.RANGE_SET = 1'(rs); end
      endcase
   endtask

   task automatic read_out(input int d, output int q, output int r, output int o, output int dn);
      case (d)
         0: begin q = bcd2int(int'(if0.Q)); r = int'(if0.RANGE); o = int'(if0.Q_OVF); dn = int'(if0.DONE); end
         1: begin q = bcd2int(int'(if1.Q)); r = int'(if1.RANGE); o = int'(if1.Q_OVF); dn = int'(if1.DONE); end
         2: begin q = bcd2int(int'(if2.Q)); r = int'(if2.RANGE); o = int'(if2.Q_OVF); dn = int'(if2.DONE); end
         default: begin q = bcd2int(int'(if3.Q)); r = int'(if3.RANGE); o = int'(if3.Q_OVF); dn = int'(if3.DONE); end
      endcase
   endtask

   task automatic wait_done(input int d, output int cyc);
      int q, r, o, dn;
      bit ok;
      ok  = 1'b0;
      cyc = 0;
      while (!ok && cyc < 1300) begin
         @(negedge clk);
         cyc++;
         read_out(d, q, r, o, dn);
         if (dn == 1) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL done_timeout dut%0d: no DONE within %0d cycles", d, cyc);
      end
   endtask

   task automatic apply_vec(input vec_t v);
      per[v.dut] = v.period;
      set_in(v.dut, v.auto_, v.rset);
      sb.push_back(v);
   endtask

   task automatic check_pop();
      vec_t e;
      int q, r, o, dn;
      e = sb.pop_front();
      read_out(e.dut, q, r, o, dn);
      chk({e.name, "_range"}, r, e.exp_range);
      chk_rng({e.name, "_q"}, q, e.q_min, e.q_max);
      chk({e.name, "_ovf"}, o, e.exp_ovf);
   endtask

   initial begin
      int q, r, o, dn, cyc, n;

      //        dut per auto rs  range qlo  qhi ovf name
      add_vec(0, 4, 1, 0, 0,   2,   3, 0, "d0_auto_r0");
      add_vec(0, 4, 1, 0, 1,  25,  25, 0, "d0_auto_r1");
      add_vec(0, 4, 1, 0, 2, 250, 250, 0, "d0_auto_r2");
      add_vec(0, 4, 1, 0, 2, 250, 250, 0, "d0_auto_r2_hold");
      add_vec(0, 4, 0, 0, 0,   2,   3, 0, "d0_man_r0");
      add_vec(0, 4, 0, 0, 0,   2,   3, 0, "d0_man_r0_b");
      add_vec(0, 4, 0, 3, 2, 250, 250, 0, "d0_man_clamp");
      add_vec(0, 4, 1, 0, 2, 250, 250, 0, "d0_auto_after_man");
      add_vec(0, 0, 1, 0, 2,   0,   1, 0, "d0_low_r2_first");
      add_vec(0, 0, 1, 0, 2,   0,   0, 0, "d0_low_r2");
      add_vec(0, 0, 0, 0, 0,   0,   0, 0, "d0_low_man0");
      add_vec(0, 0, 1, 0, 0,   0,   0, 0, "d0_low_auto_r0");
      add_vec(0, 0, 1, 0, 1,   0,   0, 0, "d0_low_auto_r1");
      add_vec(0, 0, 1, 0, 2,   0,   0, 0, "d0_low_auto_r2");
      add_vec(0, 0, 1, 0, 2,   0,   0, 0, "d0_low_auto_hold");
      add_vec(1, 2, 0, 2, 2,  99,  99, 1, "d1_man_ovf");
      add_vec(1, 2, 0, 2, 2,  99,  99, 1, "d1_man_ovf_b");
      add_vec(1, 2, 1, 0, 2,  99,  99, 1, "d1_auto_first");
      add_vec(1, 2, 1, 0, 1,  50,  50, 0, "d1_auto_r1");
      add_vec(1, 2, 1, 0, 1,  50,  50, 0, "d1_auto_r1_hold");
      add_vec(2, 2, 1, 0, 0,   5,   5, 0, "d2_n1");
      add_vec(2, 2, 0, 1, 0,   5,   5, 0, "d2_n1_clamp");
      add_vec(3, 2, 1, 0, 0,   9,   9, 1, "d3_n1_ovf");
      add_vec(3, 2, 0, 0, 0,   9,   9, 1, "d3_n1_ovf_man");

      rst_n = 1'b0;
      set_in(1, 0, 2);
      set_in(2, 1, 0);
      set_in(3, 1, 0);
      apply_vec(vecs[0]);
      #1;
      read_out(0, q, r, o, dn);
      chk("rst_q", q, 0);
      chk("rst_range", r, 0);
      chk("rst_ovf", o, 0);
      chk("rst_done", dn, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 1; i < vecs.size(); i++) begin
         if (sb.size() > 0 && sb[0].dut != vecs[i].dut) begin
            wait_done(sb[0].dut, cyc);
            check_pop();
         end
         wait_done(vecs[i].dut, cyc);
         if (sb.size() > 0) check_pop();
         apply_vec(vecs[i]);
      end
      wait_done(sb[0].dut, cyc);
      check_pop();

      // DONE period at range 2 and pulse width.
      wait_done(0, cyc);
      wait_done(0, cyc);
      chk("d0_done_period_r2", cyc, 1002);
      @(negedge clk);
      read_out(0, q, r, o, dn);
      chk("d0_done_width", dn, 0);

      // RANGE_SET change in the middle of a gate applies only to the next measurement.
      per[0] = 4;
      set_in(0, 0, 0);
      wait_done(0, cyc);
      wait_done(0, cyc);
      read_out(0, q, r, o, dn);
      chk("d0_mid_pre_range", r, 0);
      repeat (5) @(negedge clk);
      set_in(0, 0, 2);
      wait_done(0, cyc);
      read_out(0, q, r, o, dn);
      chk("d0_mid_keep_range", r, 0);
      chk_rng("d0_mid_keep_q", q, 2, 3);
      wait_done(0, cyc);
      read_out(0, q, r, o, dn);
      chk("d0_mid_next_range", r, 2);
      chk("d0_mid_next_q", q, 250);

      // Reset in the middle of a range-2 gate.
      repeat (300) @(negedge clk);
      set_in(0, 0, 0);
      rst_n = 1'b0;
      #1;
      read_out(0, q, r, o, dn);
      chk("midrst_q", q, 0);
      chk("midrst_range", r, 0);
      chk("midrst_ovf", o, 0);
      chk("midrst_done", dn, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n  = 0;
      dn = 0;
      while (dn == 0 && n < 40) begin
         @(posedge clk);
         n++;
         #1;
         read_out(0, q, r, o, dn);
      end
      chk_rng("midrst_first_done_cycles", n, 12, 14);
      chk("midrst_first_range", r, 0);
      chk_rng("midrst_first_q", q, 2, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
